// File: rtl/compare_pkg.sv
// Shared definitions for the serial operand loader and the equality comparator.
// Build option LOADER_LSB_FIRST_EN selects LSB-first serial streams in the loader.
package compare_pkg;

    typedef enum logic {
        S_SHIFT = 1'b0,
        S_HOLD  = 1'b1
    } loader_state_e;

    localparam int DEFAULT_WIDTH = 6;

    // Ceiling log2, used to size the bit counter (returns at least 1 for value >= 2).
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 <<< i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/operand_pair_loader_bit_shift_reg.sv
// Serial-in shift register for one operand stream.
// Build option LOADER_LSB_FIRST_EN shifts toward the LSB (LSB-first streams); default is MSB first.
module bit_shift_reg
    import compare_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             din,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_shift
);

    logic [WIDTH-1:0] shreg_q;
    logic [WIDTH-1:0] shreg_d;
    logic [WIDTH-1:0] shifted_s;

    // Word as it will look once din is shifted in; the top uses it to bypass on the final beat.
    always_comb begin
`ifdef LOADER_LSB_FIRST_EN
        shifted_s = {din, shreg_q[WIDTH-1:1]};
`else
        shifted_s = {shreg_q[WIDTH-2:0], din};
`endif
        if (en) begin
            shreg_d = shifted_s;
        end else begin
            shreg_d = shreg_q;
        end
    end

    // Shift register state.
    always_ff @(posedge clk) begin
        if (reset) begin
            shreg_q <= {WIDTH{1'b0}};
        end else begin
            shreg_q <= shreg_d;
        end
    end

    assign q       = shreg_q;
    assign q_shift = shifted_s;

endmodule

// File: rtl/operand_pair_loader.sv
// Assembles serial A/B bit streams into WIDTH-bit pairs behind a double-buffered valid/ready output.
// Build option LOADER_LSB_FIRST_EN selects LSB-first streams; handshake and latency are unchanged.
module operand_pair_loader
    import compare_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ser_valid,
    input  logic             ser_a,
    input  logic             ser_b,
    output logic             ser_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_a,
    output logic [WIDTH-1:0] out_b,
    output logic [CNT_W-1:0] pair_cnt
);

    localparam int              BC_W     = clog2(WIDTH);
    localparam logic [BC_W-1:0] LAST_BIT = BC_W'(WIDTH - 1);

    loader_state_e    state_q, state_d;
    logic [BC_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_a_q, out_a_d;
    logic [WIDTH-1:0] out_b_q, out_b_d;
    logic [CNT_W-1:0] pair_cnt_q, pair_cnt_d;

    logic [WIDTH-1:0] sh_a_q, sh_a_nxt;
    logic [WIDTH-1:0] sh_b_q, sh_b_nxt;
    logic             accept_s;
    logic             out_free_s;
    logic             fire_s;

    assign ser_ready  = (state_q == S_SHIFT);
    assign accept_s   = ser_valid && ser_ready;
    assign out_free_s = !out_valid_q || out_ready;
    assign fire_s     = out_valid_q && out_ready;

    bit_shift_reg #(.WIDTH(WIDTH)) u_shift_a (
        .clk     (clk),
        .reset   (reset),
        .en      (accept_s),
        .din     (ser_a),
        .q       (sh_a_q),
        .q_shift (sh_a_nxt)
    );

    bit_shift_reg #(.WIDTH(WIDTH)) u_shift_b (
        .clk     (clk),
        .reset   (reset),
        .en      (accept_s),
        .din     (ser_b),
        .q       (sh_b_q),
        .q_shift (sh_b_nxt)
    );

    // Next-state logic: a load into the output stage overrides the consume-clear of out_valid.
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        out_a_d     = out_a_q;
        out_b_d     = out_b_q;
        out_valid_d = fire_s ? 1'b0 : out_valid_q;
        pair_cnt_d  = fire_s ? (pair_cnt_q + CNT_W'(1)) : pair_cnt_q;

        case (state_q)
            S_SHIFT: begin
                if (accept_s) begin
                    if (bit_cnt_q == LAST_BIT) begin
                        if (out_free_s) begin
                            out_a_d     = sh_a_nxt;
                            out_b_d     = sh_b_nxt;
                            out_valid_d = 1'b1;
                            bit_cnt_d   = {BC_W{1'b0}};
                        end else begin
                            state_d = S_HOLD;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + BC_W'(1);
                    end
                end else begin
                    state_d = S_SHIFT;
                end
            end
            S_HOLD: begin
                // Completed word is parked in the shift stage until the output slot frees.
                if (out_free_s) begin
                    out_a_d     = sh_a_q;
                    out_b_d     = sh_b_q;
                    out_valid_d = 1'b1;
                    bit_cnt_d   = {BC_W{1'b0}};
                    state_d     = S_SHIFT;
                end else begin
                    state_d = S_HOLD;
                end
            end
            default: begin
                state_d = S_SHIFT;
            end
        endcase
    end

    // Control, output stage and delivered-pair counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_SHIFT;
            bit_cnt_q   <= {BC_W{1'b0}};
            out_valid_q <= 1'b0;
            out_a_q     <= {WIDTH{1'b0}};
            out_b_q     <= {WIDTH{1'b0}};
            pair_cnt_q  <= {CNT_W{1'b0}};
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            out_valid_q <= out_valid_d;
            out_a_q     <= out_a_d;
            out_b_q     <= out_b_d;
            pair_cnt_q  <= pair_cnt_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_a     = out_a_q;
    assign out_b     = out_b_q;
    assign pair_cnt  = pair_cnt_q;

endmodule
